// File: rtl/risc32i_pkg.sv
// Shared risc32i definitions: widths, base opcodes, immediate formats,
// the ID/EX bundle and small opcode-classification helpers.
package risc32i_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_e;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_val;
        logic [XLEN-1:0]   rs2_val;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rd;
        logic [6:0]        opcode;
        logic [2:0]        funct3;
        logic              funct7_5;
        logic              illegal;
    } id_ex_t;

    // Immediate layout implied by the opcode; R-type and unknown opcodes carry none.
    function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opcode);
        case (opcode)
            OP_IMM, LOAD, JALR, SYSTEM: return IMM_I;
            STORE:                      return IMM_S;
            BRANCH:                     return IMM_B;
            LUI, AUIPC:                 return IMM_U;
            JAL:                        return IMM_J;
            default:                    return IMM_NONE;
        endcase
    endfunction

    function automatic logic is_legal_op(input logic [6:0] opcode);
        case (opcode)
            OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs1(input logic [6:0] opcode);
        case (opcode)
            OP, STORE, BRANCH, OP_IMM, LOAD, JALR, SYSTEM: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        case (opcode)
            OP, STORE, BRANCH: return 1'b1;
            default:           return 1'b0;
        endcase
    endfunction

    // Stores, branches and unknown opcodes write no register.
    function automatic logic has_rd(input logic [6:0] opcode);
        case (opcode)
            OP, OP_IMM, LOAD, JAL, JALR, LUI, AUIPC, SYSTEM: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_imm_gen.sv
// Combinational immediate generator: picks the format from the opcode
// and sign-extends to XLEN.
module imm_gen
    import risc32i_pkg::*;
(
    input  logic [XLEN-1:0] instr_i,
    output logic [XLEN-1:0] imm_o
);

    // Assemble the immediate for the decoded format.
    always_comb begin
        imm_o = '0;
        case (imm_fmt_of(instr_i[6:0]))
            IMM_I:   imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S:   imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:   imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                              instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U:   imm_o = {instr_i[31:12], 12'h000};
            IMM_J:   imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                              instr_i[20], instr_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// risc32i instruction-decode stage: register read addressing, writeback
// bypass, load-use stall, immediate generation and the ID/EX register.
module id_stage
    import risc32i_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic [REG_AW-1:0] rs1_addr,
    output logic [REG_AW-1:0] rs2_addr,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_rs1_val,
    output logic [XLEN-1:0]   out_rs2_val,
    output logic [XLEN-1:0]   out_imm,
    output logic [REG_AW-1:0] out_rd,
    output logic [6:0]        out_opcode,
    output logic [2:0]        out_funct3,
    output logic              out_funct7_5,
    output logic              out_illegal
);

    logic [6:0]      opcode;
    logic [XLEN-1:0] imm;
    logic            hazard;
    logic            accept;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    id_ex_t          bundle_d;
    id_ex_t          bundle_q;
    logic            valid_q;

    assign opcode   = in_instr[6:0];
    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];

    imm_gen u_imm_gen (
        .instr_i (in_instr),
        .imm_o   (imm)
    );

    // Operand select: x0 reads zero, then same-cycle writeback wins over the RegFile value.
    always_comb begin
        rs1_val = rs1_data;
        rs2_val = rs2_data;
        if (rs1_addr == '0)
            rs1_val = '0;
        else if (wb_we && (wb_rd == rs1_addr))
            rs1_val = wb_data;
        if (rs2_addr == '0)
            rs2_val = '0;
        else if (wb_we && (wb_rd == rs2_addr))
            rs2_val = wb_data;
    end

    // Load-use stall only for sources the instruction actually reads.
    always_comb begin
        hazard = in_valid && ex_is_load && (ex_rd != '0) &&
                 ((uses_rs1(opcode) && (ex_rd == rs1_addr)) ||
                  (uses_rs2(opcode) && (ex_rd == rs2_addr)));
        in_ready = !hazard && (!valid_q || out_ready);
        accept   = in_valid && in_ready;
    end

    // Decoded bundle presented to the ID/EX register.
    always_comb begin
        bundle_d          = '0;
        bundle_d.pc       = in_pc;
        bundle_d.rs1_val  = rs1_val;
        bundle_d.rs2_val  = rs2_val;
        bundle_d.imm      = imm;
        bundle_d.rd       = has_rd(opcode) ? in_instr[11:7] : '0;
        bundle_d.opcode   = opcode;
        bundle_d.funct3   = in_instr[14:12];
        bundle_d.funct7_5 = in_instr[30];
        bundle_d.illegal  = !is_legal_op(opcode);
    end

    // ID/EX register: reset, then flush, then accept; a consumed bundle with no replacement becomes a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else if (flush) begin
            valid_q  <= 1'b0;
        end else if (accept) begin
            valid_q  <= 1'b1;
            bundle_q <= bundle_d;
        end else if (out_ready) begin
            valid_q  <= 1'b0;
        end
    end

    assign out_valid    = valid_q;
    assign out_pc       = bundle_q.pc;
    assign out_rs1_val  = bundle_q.rs1_val;
    assign out_rs2_val  = bundle_q.rs2_val;
    assign out_imm      = bundle_q.imm;
    assign out_rd       = bundle_q.rd;
    assign out_opcode   = bundle_q.opcode;
    assign out_funct3   = bundle_q.funct3;
    assign out_funct7_5 = bundle_q.funct7_5;
    assign out_illegal  = bundle_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: hand-assembled instructions with
// hand-computed decode results.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_rs1_val;
    logic [31:0] out_rs2_val;
    logic [31:0] out_imm;
    logic [4:0]  out_rd;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic        out_funct7_5;
    logic        out_illegal;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    id_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .ex_is_load   (ex_is_load),
        .ex_rd        (ex_rd),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_rs1_val  (out_rs1_val),
        .out_rs2_val  (out_rs2_val),
        .out_imm      (out_imm),
        .out_rd       (out_rd),
        .out_opcode   (out_opcode),
        .out_funct3   (out_funct3),
        .out_funct7_5 (out_funct7_5),
        .out_illegal  (out_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // One clock; inputs are then driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs settle before combinational outputs are sampled.
    task automatic settle();
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b1;
        in_instr   = 32'h0050_0093;     // addi x1,x0,5
        in_pc      = 32'h0000_0100;
        rs1_data   = 32'h0;
        rs2_data   = 32'h0;
        wb_we      = 1'b0;
        wb_rd      = 5'd0;
        wb_data    = 32'h0;
        ex_is_load = 1'b0;
        ex_rd      = 5'd0;
        flush      = 1'b0;
        out_ready  = 1'b1;

        // Reset with a valid instruction present
        tick();
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_imm", out_imm, 32'h0);
        chk("rst_rd", {27'b0, out_rd}, 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        chk("addi_rs2_addr", {27'b0, rs2_addr}, 32'd5);

        // addi x1,x0,5
        rst = 1'b0;
        settle();
        chk("addi_in_ready", {31'b0, in_ready}, 32'h1);
        tick();
        chk("addi_valid", {31'b0, out_valid}, 32'h1);
        chk("addi_rd", {27'b0, out_rd}, 32'd1);
        chk("addi_imm", out_imm, 32'd5);
        chk("addi_rs1", out_rs1_val, 32'h0);
        chk("addi_pc", out_pc, 32'h100);
        chk("addi_opcode", {25'b0, out_opcode}, 32'h13);
        chk("addi_illegal", {31'b0, out_illegal}, 32'h0);

        // add x3,x2,x2 with x2 bypassed from writeback
        in_instr = 32'h0021_01B3;
        in_pc    = 32'h0000_0104;
        wb_we    = 1'b1;
        wb_rd    = 5'd2;
        wb_data  = 32'd10;
        settle();
        chk("add_rs1_addr", {27'b0, rs1_addr}, 32'd2);
        chk("add_rs2_addr", {27'b0, rs2_addr}, 32'd2);
        tick();
        chk("byp_rs1", out_rs1_val, 32'd10);
        chk("byp_rs2", out_rs2_val, 32'd10);
        chk("byp_rd", {27'b0, out_rd}, 32'd3);
        chk("byp_imm", out_imm, 32'h0);

        // Same add, writeback to another register: RegFile data used
        rs1_data = 32'h11;
        rs2_data = 32'h22;
        wb_rd    = 5'd7;
        tick();
        chk("nobyp_rs1", out_rs1_val, 32'h11);
        chk("nobyp_rs2", out_rs2_val, 32'h22);

        // add x4,x0,x0 with writeback to x0: x0 stays zero
        in_instr = 32'h0000_0233;
        wb_rd    = 5'd0;
        wb_data  = 32'd7;
        rs1_data = 32'h55;
        rs2_data = 32'h55;
        tick();
        chk("x0_rs1", out_rs1_val, 32'h0);
        chk("x0_rs2", out_rs2_val, 32'h0);
        chk("x0_rd", {27'b0, out_rd}, 32'd4);
        wb_we = 1'b0;

        // Load-use on rs1: add x6,x5,x1 with load to x5 in EX
        in_instr   = 32'h0012_8333;
        ex_is_load = 1'b1;
        ex_rd      = 5'd5;
        settle();
        chk("lu_rs1_ready", {31'b0, in_ready}, 32'h0);
        tick();
        chk("lu_bubble", {31'b0, out_valid}, 32'h0);
        // Load-use on rs2 (x1)
        ex_rd = 5'd1;
        settle();
        chk("lu_rs2_ready", {31'b0, in_ready}, 32'h0);
        ex_is_load = 1'b0;
        settle();
        chk("lu_clear_ready", {31'b0, in_ready}, 32'h1);
        tick();
        chk("lu_retry_valid", {31'b0, out_valid}, 32'h1);
        chk("lu_retry_rd", {27'b0, out_rd}, 32'd6);

        // lui x5,0x12345: rs1 field decodes to 8 but is unused, no stall
        in_instr   = 32'h1234_52B7;
        ex_is_load = 1'b1;
        ex_rd      = 5'd8;
        settle();
        chk("lui_rs1_field", {27'b0, rs1_addr}, 32'd8);
        chk("lui_ready", {31'b0, in_ready}, 32'h1);
        tick();
        chk("lui_imm", out_imm, 32'h1234_5000);
        chk("lui_rd", {27'b0, out_rd}, 32'd5);
        ex_is_load = 1'b0;

        // Backpressure for 3 cycles with addi x7,x0,3 waiting
        in_instr  = 32'h0030_0393;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("bp_ready", {31'b0, in_ready}, 32'h0);
            tick();
            chk("bp_valid", {31'b0, out_valid}, 32'h1);
            chk("bp_imm_hold", out_imm, 32'h1234_5000);
            chk("bp_rd_hold", {27'b0, out_rd}, 32'd5);
        end
        out_ready = 1'b1;
        settle();
        chk("bp_release_ready", {31'b0, in_ready}, 32'h1);
        tick();
        chk("bp_next_imm", out_imm, 32'd3);
        chk("bp_next_rd", {27'b0, out_rd}, 32'd7);

        // Flush with a same-cycle accept
        flush = 1'b1;
        tick();
        chk("flush_valid", {31'b0, out_valid}, 32'h0);
        flush = 1'b0;

        // Illegal opcode 0x7F
        in_instr = 32'h0000_007F;
        tick();
        chk("ill_valid", {31'b0, out_valid}, 32'h1);
        chk("ill_flag", {31'b0, out_illegal}, 32'h1);
        chk("ill_rd", {27'b0, out_rd}, 32'h0);
        chk("ill_imm", out_imm, 32'h0);
        // Illegal opcode with a nonzero rd field
        in_instr = 32'h0000_0FFF;
        tick();
        chk("ill2_flag", {31'b0, out_illegal}, 32'h1);
        chk("ill2_rd", {27'b0, out_rd}, 32'h0);

        // beq x0,x0,-4
        in_instr = 32'hFE00_0EE3;
        tick();
        chk("beq_imm", out_imm, 32'hFFFF_FFFC);
        chk("beq_rd", {27'b0, out_rd}, 32'h0);
        chk("beq_illegal", {31'b0, out_illegal}, 32'h0);

        // sw x2,-8(x1)
        in_instr = 32'hFE20_AC23;
        tick();
        chk("sw_imm", out_imm, 32'hFFFF_FFF8);
        chk("sw_funct3", {29'b0, out_funct3}, 32'd2);
        chk("sw_rd", {27'b0, out_rd}, 32'h0);

        // jal x1,8
        in_instr = 32'h0080_00EF;
        tick();
        chk("jal_imm", out_imm, 32'd8);
        chk("jal_rd", {27'b0, out_rd}, 32'd1);

        // sub x3,x2,x2 exercises funct7[5]
        in_instr = 32'h4021_01B3;
        tick();
        chk("sub_f7", {31'b0, out_funct7_5}, 32'h1);

        // Reset during a stall clears out_valid and captures nothing
        out_ready = 1'b0;
        in_instr  = 32'h0050_0093;
        rst       = 1'b1;
        tick();
        chk("rst_stall_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_stall_imm", out_imm, 32'h0);
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("idle_valid", {31'b0, out_valid}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the risc32i pipeline, sitting directly upstream of RegFile.
- Accepts a fetched instruction and drives RegFile's two read addresses. It takes the returned read data and bypasses same-cycle writeback data into it.
- Detects load-use hazards, generates the immediate and registers the decoded bundle into the ID/EX register with a valid/ready handshake toward EX.

Parameters:
- XLEN, 32, datapath and instruction width.
- REG_AW, 5, register address width (32 architectural registers, x0 hardwired zero).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_instr  in  XLEN  instruction word
- in_pc  in  XLEN  instruction address
- rs1_addr  out  REG_AW  to RegFile R1
- rs2_addr  out  REG_AW  to RegFile R2
- rs1_data  in  XLEN  from RegFile R1_data
- rs2_data  in  XLEN  from RegFile R2_data
- wb_we  in  1  writeback enable (same signal as RegFile reg_write_enable)
- wb_rd  in  REG_AW  writeback destination (same as RegFile RD)
- wb_data  in  XLEN  writeback value (same as RegFile RD_DATA)
- ex_is_load  in  1  instruction currently in EX is a load
- ex_rd  in  REG_AW  destination of the instruction in EX
- flush  in  1  kill the instruction in ID/EX and the one being accepted (branch redirect)
- out_valid  out  1  ID/EX holds a valid bundle
- out_ready  in  1  EX consumes the bundle
- out_pc, out_rs1_val, out_rs2_val, out_imm  out  XLEN  registered bundle fields
- out_rd  out  REG_AW  destination register (0 when the format has no rd)
- out_opcode  out  7, out_funct3  out  3, out_funct7_5  out  1  control fields
- out_illegal  out  1  opcode not one of the RV32I base opcodes

Behaviour:
- Reset (rst=1 at posedge): out_valid=0; all out_* data fields=0. in_ready is combinational and still follows the rules below.
- rs1_addr=in_instr[19:15] and rs2_addr=in_instr[24:20], always combinational from in_instr.
- Register usage by opcode:
  - R, S, B types use rs1 and rs2.
  - I type (OP-IMM, LOAD, JALR) and SYSTEM use rs1 only.
  - LUI, AUIPC and JAL use neither.
- Operand value, evaluated per source in priority order:
  - Address 0 gives 0.
  - Otherwise, if wb_we and wb_rd==addr, use wb_data (bypass).
  - Otherwise use rsN_data.
- Immediate: I, S, B, U and J formats, sign-extended to XLEN. B and J have bit0=0. Illegal or R-type gives imm=0.
- hazard = in_valid & ex_is_load & ex_rd!=0 & ((uses_rs1 & ex_rd==rs1_addr) | (uses_rs2 & ex_rd==rs2_addr)).
- in_ready = !hazard & (!out_valid | out_ready).
- Accept = in_valid & in_ready. On accept, the bundle is captured at the next posedge (latency 1) and out_valid becomes 1.
- Hazard with EX consuming: out_valid goes 0 (bubble) and the instruction is held upstream. It is retried the next cycle.
- out_valid & !out_ready: all out_* stay stable and in_ready=0.
- flush=1: at the next posedge out_valid=0. Any same-cycle accept is discarded, and flush overrides accept.
- rst has priority over flush and accept. Reset mid-stall clears out_valid; nothing is captured that cycle.
- out_illegal=1 for an unknown opcode. The bundle is still passed through, with out_rd=0.

Decomposition:
- Shared package risc32i_pkg:
  - Opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM).
  - Immediate-format enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE).
  - XLEN and REG_AW constants.
- One natural sub-module: imm_gen, combinational, instr in → imm out, format selected from the opcode.

Test Plan:
- Reset with in_valid=1: out_valid=0, out_imm=0. After releasing rst, addi x1,x0,5 (0x00500093) accepted → next cycle out_rd=1, out_imm=5, out_rs1_val=0, out_valid=1.
- Bypass: RegFile x2 holds 0 while wb_we=1, wb_rd=2, wb_data=10 and add x3,x2,x2 is accepted → out_rs1_val=out_rs2_val=10.
- Bypass to x0: wb_we=1, wb_rd=0, wb_data=7 and add x4,x0,x0 → both operands 0.
- Load-use: ex_is_load=1, ex_rd=5, in_instr=add x6,x5,x1 → in_ready=0 and out_valid=0 next cycle. Then ex_is_load=0 → accepted the following cycle. Same stimulus with lui x5 instead: no stall.
- Backpressure: out_ready=0 for 3 cycles → in_ready=0 and the bundle is held unchanged. out_ready=1 → the next instruction is captured.
- Flush plus accept in the same cycle → out_valid=0 next cycle. Illegal opcode 0x0000007F → out_illegal=1, out_rd=0. beq imm=-4 (0xFE000EE3) → out_imm=0xFFFFFFFC.
